// File: rtl/hmm_path_scorer_if.sv
// Token stream into the HMM path scorer.
// Master drives word/pos/last tokens; slave returns ready.
interface hmm_path_scorer_if #(
    parameter int word_num_bit = 4,
    parameter int POS_num_bit  = 4
);
    logic                    in_valid;
    logic                    in_ready;
    logic [word_num_bit-1:0] in_word;
    logic [POS_num_bit-1:0]  in_pos;
    logic                    in_last;

    modport master (
        output in_valid,
        output in_word,
        output in_pos,
        output in_last,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_word,
        input  in_pos,
        input  in_last,
        output in_ready
    );
endinterface

// File: rtl/hmm_path_scorer.sv
// Joint HMM path probability of a (word, POS) sequence in Q0.32.
// Reads transition and emission tables through registered read ports.
module hmm_path_scorer #(
    parameter int word_num     = 16,
    parameter int word_num_bit = 4,
    parameter int p_size       = 32,
    parameter int POS_num      = 11,
    parameter int POS_num_bit  = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    hmm_path_scorer_if.slave        tok,
    output logic [POS_num_bit-1:0]  trans_prev,
    output logic [POS_num_bit-1:0]  trans_curr,
    input  logic [p_size-1:0]       trans_data,
    output logic [word_num_bit-1:0] emiss_word,
    output logic [POS_num_bit-1:0]  emiss_pos,
    input  logic [p_size-1:0]       emiss_data,
    output logic [p_size-1:0]       score,
    output logic [word_num_bit:0]   length,
    output logic                    busy,
    output logic                    done,
    output logic                    error
);
    typedef enum logic [2:0] {
        IDLE, ACCEPT, FETCH, MUL_T, MUL_E, FIN, ERR
    } state_e;

    localparam logic [POS_num_bit-1:0] START_ROW = POS_num_bit'(POS_num);
    localparam logic [word_num_bit:0]  LEN_MAX   = (word_num_bit + 1)'(word_num);
    localparam logic [p_size-1:0]      ONE       = '1;

    state_e                  state_q, state_d;
    logic [p_size-1:0]       score_q, score_d;
    logic [word_num_bit:0]   length_q, length_d;
    logic [POS_num_bit-1:0]  prev_q, prev_d;
    logic [POS_num_bit-1:0]  pos_q, pos_d;
    logic                    last_q, last_d;
    logic [p_size-1:0]       emiss_reg_q, emiss_reg_d;
    logic [POS_num_bit-1:0]  trans_prev_q, trans_prev_d;
    logic [POS_num_bit-1:0]  trans_curr_q, trans_curr_d;
    logic [word_num_bit-1:0] emiss_word_q, emiss_word_d;
    logic [POS_num_bit-1:0]  emiss_pos_q, emiss_pos_d;

    logic [2*p_size-1:0]     prod_t;
    logic [2*p_size-1:0]     prod_e;
    logic                    restart;

    // Truncating Q0.32 multiply: keep the upper half of the product.
    assign prod_t = {{p_size{1'b0}}, score_q} * {{p_size{1'b0}}, trans_data};
    assign prod_e = {{p_size{1'b0}}, score_q} * {{p_size{1'b0}}, emiss_reg_q};

    assign restart = start &&
        (state_q == IDLE || state_q == FIN || state_q == ERR);

    always_comb begin
        state_d      = state_q;
        score_d      = score_q;
        length_d     = length_q;
        prev_d       = prev_q;
        pos_d        = pos_q;
        last_d       = last_q;
        emiss_reg_d  = emiss_reg_q;
        trans_prev_d = trans_prev_q;
        trans_curr_d = trans_curr_q;
        emiss_word_d = emiss_word_q;
        emiss_pos_d  = emiss_pos_q;

        unique case (state_q)
            ACCEPT: begin
                if (tok.in_valid) begin
                    pos_d  = tok.in_pos;
                    last_d = tok.in_last;
                    if (tok.in_pos >= START_ROW || length_q == LEN_MAX) begin
                        state_d = ERR;
                    end else begin
                        state_d      = FETCH;
                        trans_prev_d = prev_q;
                        trans_curr_d = tok.in_pos;
                        emiss_word_d = tok.in_word;
                        emiss_pos_d  = tok.in_pos;
                    end
                end
            end
            FETCH: begin
                state_d = MUL_T;
            end
            MUL_T: begin
                score_d     = prod_t[2*p_size-1:p_size];
                emiss_reg_d = emiss_data;
                state_d     = MUL_E;
            end
            MUL_E: begin
                score_d  = prod_e[2*p_size-1:p_size];
                prev_d   = pos_q;
                length_d = length_q + 1'b1;
                state_d  = last_q ? FIN : ACCEPT;
            end
            FIN: begin
                state_d = IDLE;
            end
            IDLE, ERR: begin
                state_d = state_q;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (restart) begin
            state_d  = ACCEPT;
            score_d  = ONE;
            length_d = '0;
            prev_d   = START_ROW;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            score_q      <= '0;
            length_q     <= '0;
            prev_q       <= START_ROW;
            pos_q        <= '0;
            last_q       <= 1'b0;
            emiss_reg_q  <= '0;
            trans_prev_q <= '0;
            trans_curr_q <= '0;
            emiss_word_q <= '0;
            emiss_pos_q  <= '0;
        end else begin
            state_q      <= state_d;
            score_q      <= score_d;
            length_q     <= length_d;
            prev_q       <= prev_d;
            pos_q        <= pos_d;
            last_q       <= last_d;
            emiss_reg_q  <= emiss_reg_d;
            trans_prev_q <= trans_prev_d;
            trans_curr_q <= trans_curr_d;
            emiss_word_q <= emiss_word_d;
            emiss_pos_q  <= emiss_pos_d;
        end
    end

    assign tok.in_ready = (state_q == ACCEPT);
    assign busy         = (state_q != IDLE) && (state_q != ERR);
    assign done         = (state_q == FIN);
    assign error        = (state_q == ERR);
    assign score        = score_q;
    assign length       = length_q;
    assign trans_prev   = trans_prev_q;
    assign trans_curr   = trans_curr_q;
    assign emiss_word   = emiss_word_q;
    assign emiss_pos    = emiss_pos_q;
endmodule

// File: doc/hmm_path_scorer.md
Name: hmm_path_scorer

Overview:
- Reverse-direction companion to the Viterbi tagger.
- The tagger turns a word sequence into the most likely POS sequence. This block takes a (word, POS) sequence and computes the joint HMM path probability:
  - score = prior(pos0) * emiss(word0,pos0) * Π trans(pos(k-1),pos(k)) * emiss(word(k),pos(k)).
- It reads the same transition and emission tables through registered read ports. It is used to score or cross-check tagger output and externally supplied tag paths.

Parameters:
- word_num, 16, max tokens per sentence.
- word_num_bit, 4, word key width.
- p_size, 32, probability width (unsigned Q0.32; 32'hFFFFFFFF represents 1.0).
- POS_num, 11, number of POS tags. Index POS_num is the START row of the transition table and supplies the prior.
- POS_num_bit, 4, POS index width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a new sentence.
- in_valid  in  1  token valid.
- in_ready  out  1  block can accept a token.
- in_word  in  word_num_bit  word key of the token.
- in_pos  in  POS_num_bit  POS tag of the token.
- in_last  in  1  token is the final word of the sentence.
- trans_prev  out  POS_num_bit  transition table row (previous POS, or START).
- trans_curr  out  POS_num_bit  transition table column (current POS).
- trans_data  in  p_size  transition probability, valid the cycle after the address.
- emiss_word  out  word_num_bit  emission table row.
- emiss_pos  out  POS_num_bit  emission table column.
- emiss_data  in  p_size  emission probability, valid the cycle after the address.
- score  out  p_size  accumulated path probability.
- length  out  word_num_bit+1  tokens scored.
- busy  out  1  sentence in progress.
- done  out  1  one-cycle pulse on successful completion.
- error  out  1  sticky error flag.

Behaviour:
- Reset (reset=0, async):
  - State IDLE.
  - score=0, length=0, all address outputs=0.
  - busy=0, done=0, error=0, in_ready=0.
  - Internal prev_pos=POS_num.
- FSM states: IDLE, ACCEPT, FETCH, MUL_T, MUL_E, FIN, ERR.
- start:
  - Sampled in IDLE, FIN or ERR.
  - Action: score<=32'hFFFFFFFF, length<=0, prev_pos<=POS_num, error<=0, then go to ACCEPT.
  - Ignored in any other state.
- ACCEPT:
  - in_ready=1. busy=1 in every state except IDLE and ERR.
  - A token is accepted on in_valid&&in_ready. On acceptance, word, pos and last are latched.
  - If in_pos>=POS_num, or length==word_num (17th token), go to ERR. Otherwise go to FETCH.
  - in_ready=0 in all other states. Exactly one token per 4 cycles at best.
- FETCH: registered outputs update: trans_prev<=prev_pos, trans_curr<=pos, emiss_word<=word, emiss_pos<=pos.
- MUL_T: table data is valid.
  - score<=(score*trans_data)>>32. The 64-bit product is truncated, no rounding.
  - emiss_data is captured into an internal register.
- MUL_E:
  - score<=(score*emiss_reg)>>32.
  - prev_pos<=pos, length<=length+1.
  - Go to FIN if last, else ACCEPT.
- FIN:
  - done=1 for exactly one cycle (the FIN entry cycle), then go to IDLE.
  - score and length hold until the next start.
- ERR:
  - error=1, held.
  - score and length freeze at their values before the offending token. done is never asserted.
  - Leave ERR only via start or reset.
- Zero probabilities propagate, so score stays 0. No saturation is needed: the product is always <= its operands.
- Latency: token accepted at cycle T; score updated at T+2 and T+3. If last, done=1 at T+4.
- Reset mid-sentence: immediate return to the reset values. Any partially processed token is discarded.
- Addresses hold their values between tokens. The tables must be read-only during scoring.

Test Plan:
- Single token:
  - Stimulus: start, token (word=3, pos=2, last=1); trans[11][2]=32'h80000000, emiss[3][2]=32'h80000000.
  - Required: trans_prev=11, trans_curr=2 in FETCH; score=32'h3FFFFFFF; length=1; done pulses 4 cycles after acceptance; error=0.
- All-ones tables, 3 tokens:
  - Required: score sequence FFFFFFFE, FFFFFFFD, …, final score=32'hFFFFFFF9; length=3; trans_prev follows prev pos.
- Invalid POS:
  - Stimulus: second token pos=11.
  - Required: error=1, done=0, length=1, score frozen, in_ready=0. A following start clears error and accepts new tokens.
- Overflow:
  - Stimulus: 16 tokens with last=0, then a 17th token.
  - Required: error=1, length=16. A 16-token sentence with last on the 16th completes normally with length=16.
- Handshake and start rules:
  - Stimulus: in_valid held high continuously; start pulses while in MUL_T.
  - Required: in_ready high only in ACCEPT; one token per 4 cycles; the start during MUL_T is ignored and the score is unchanged.
- Reset mid-sentence:
  - Stimulus: reset=0 during MUL_E.
  - Required: all outputs return to reset values asynchronously; the next start scores a fresh sentence correctly.
